// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the processing-element multiplier.
// Field widths, bias, canonical special encodings, FSM state type and
// the packed {sign, exp, man} view of a binary16 word.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } pu_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational RNE rounding and packing of a normalised FP16 product.
// Ports: sign, signed biased exponent, 10-bit fraction, guard/round/sticky,
// special flags (nan/inf/zero) in; packed 16-bit result out. No latency.
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic              sign,
    input  logic signed [6:0] exp_in,
    input  logic [MAN_W-1:0]  man_in,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    input  logic              is_nan,
    input  logic              is_inf,
    input  logic              is_zero,
    output logic [15:0]       result
);

    localparam logic signed [7:0] EMAX = 8'(EXP_MAX);

    logic              round_up;
    logic [MAN_W:0]    man_sum;
    logic signed [7:0] exp_fin;

    always_comb begin
        round_up = guard & (rnd | sticky | man_in[0]);
        man_sum  = {1'b0, man_in} + {{MAN_W{1'b0}}, round_up};
        // A carry out of the fraction means 1.111.. rounded up to 10.000..;
        // the fraction bits are already zero, only the exponent moves.
        exp_fin  = {exp_in[6], exp_in} + {7'd0, man_sum[MAN_W]};

        if (is_nan) begin
            result = FP16_QNAN;
        end else if (is_inf) begin
            result = {sign, FP16_INF[14:0]};
        end else if (is_zero) begin
            result = {sign, 15'd0};
        end else if (exp_fin >= EMAX) begin
            result = {sign, FP16_INF[14:0]};
        end else if (exp_fin <= 8'sd0) begin
            result = {sign, 15'd0};
        end else begin
            result = {sign, exp_fin[EXP_W-1:0], man_sum[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/processing_unit.sv
// Multi-cycle FP16 multiplier: latch a/b on start, P = a*b via MUL/NORM/ROUND.
// Ports: clk, reset (async active-low), start, a, b in; P (registered), ready out.
// ready is high in DONE only; start is sampled in IDLE or DONE, ignored while busy.
module processing_unit
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] P,
    output logic        ready
);

    pu_state_t state, state_nxt;

    fp16_t             a_r, b_r;
    logic              sign_r;
    logic signed [6:0] exp_r;
    logic [21:0]       prod_r;
    logic              nan_r, inf_r, zero_r;
    logic [MAN_W-1:0]  man_r;
    logic              g_r, r_r, s_r;

    // Operand classification on the latched operands (used in MUL).
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] prod_c;
    logic [6:0]  exp_sum_c;
    logic [15:0] packed_res;

    // Subnormals (exp==0, man!=0) are treated as zero: flush-to-zero inputs.
    assign a_zero = (a_r.exp == '0);
    assign b_zero = (b_r.exp == '0);
    assign a_inf  = (a_r.exp == '1) && (a_r.man == '0);
    assign b_inf  = (b_r.exp == '1) && (b_r.man == '0);
    assign a_nan  = (a_r.exp == '1) && (a_r.man != '0);
    assign b_nan  = (b_r.exp == '1) && (b_r.man != '0);

    assign prod_c    = 22'({1'b1, a_r.man}) * 22'({1'b1, b_r.man});
    // Range -13..45 fits a 7-bit signed value.
    assign exp_sum_c = {2'b00, a_r.exp} + {2'b00, b_r.exp} - 7'(BIAS);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = start ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ready = (state == DONE);
    end

    fp16_round_pack u_round_pack (
        .sign    (sign_r),
        .exp_in  (exp_r),
        .man_in  (man_r),
        .guard   (g_r),
        .rnd     (r_r),
        .sticky  (s_r),
        .is_nan  (nan_r),
        .is_inf  (inf_r),
        .is_zero (zero_r),
        .result  (packed_res)
    );

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r    <= '0;
            b_r    <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            prod_r <= '0;
            nan_r  <= 1'b0;
            inf_r  <= 1'b0;
            zero_r <= 1'b0;
            man_r  <= '0;
            g_r    <= 1'b0;
            r_r    <= 1'b0;
            s_r    <= 1'b0;
            P      <= 16'h0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                MUL: begin
                    sign_r <= a_r.sign ^ b_r.sign;
                    exp_r  <= exp_sum_c;
                    prod_r <= prod_c;
                    nan_r  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                    inf_r  <= a_inf | b_inf;
                    zero_r <= a_zero | b_zero;
                end
                NORM: begin
                    // Product of two 1.x values lies in [1,4); bit 21 set means [2,4).
                    if (prod_r[21]) begin
                        exp_r <= exp_r + 7'sd1;
                        man_r <= prod_r[20:11];
                        g_r   <= prod_r[10];
                        r_r   <= prod_r[9];
                        s_r   <= |prod_r[8:0];
                    end else begin
                        man_r <= prod_r[19:10];
                        g_r   <= prod_r[9];
                        r_r   <= prod_r[8];
                        s_r   <= |prod_r[7:0];
                    end
                end
                ROUND: begin
                    P <= packed_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_processing_unit.sv
module tb_processing_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic [15:0] P;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    processing_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .P     (P),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: value-level arithmetic on reals, then IEEE RNE encoding
    // with flush-to-zero on both inputs and outputs.
    function automatic real fp_mag(input logic [15:0] x);
        real v;
        int  e;
        if (x[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(x[9:0]) / 1024.0;
        e = int'(x[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return v;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic s, xn, yn, xi, yi, xz, yz;
        real  p, m, fl;
        int   e, mi, be;
        s  = x[15] ^ y[15];
        xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
        yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
        xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
        yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
        xz = (x[14:10] == 5'h00);
        yz = (y[14:10] == 5'h00);
        if (xn || yn || (xi && yz) || (yi && xz)) return 16'h7E00;
        if (xi || yi) return {s, 15'h7C00};
        if (xz || yz) return {s, 15'h0000};
        p = fp_mag(x) * fp_mag(y);
        e = 0;
        while (p >= 2.0) begin p = p / 2.0; e++; end
        while (p < 1.0)  begin p = p * 2.0; e--; end
        m  = p * 1024.0;
        fl = $floor(m);
        mi = $rtoi(fl);
        if ((m - fl) > 0.5 || ((m - fl) == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        be = e + 15;
        if (be >= 31) return {s, 15'h7C00};
        if (be <= 0)  return {s, 15'h0000};
        return {s, 5'(be), 10'(mi)};
    endfunction

    // One launch with a single-cycle start; a/b are scrambled while busy.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input string tag);
        int          edges;
        logic [15:0] want;
        want = ref_mul(x, y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        edges = 1;
        while (!ready && edges < 12) begin
            @(negedge clk);
            edges++;
        end
        check_eq({tag, " latency"}, edges, 4);
        check_eq({tag, " P"}, P, want);
        @(negedge clk);
        check_eq({tag, " ready drop"}, ready, 0);
        check_eq({tag, " P hold"}, P, want);
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] sp [9];
        int r;
        sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
               16'h0001, 16'h0400, 16'h7BFF, 16'h3C00};
        r = $urandom_range(0, 9);
        if (r < 2)  return sp[$urandom_range(0, 8)];
        if (r == 9) return 16'($urandom);
        return {1'($urandom), 5'($urandom_range(5, 25)), 10'($urandom)};
    endfunction

    initial begin
        int cyc, pulses, last, gap_bad;
        logic [15:0] ra, rb;

        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check_eq("reset P", P, 16'h0000);
        check_eq("reset ready", ready, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check_eq("idle no ready", pulses, 0);

        // Directed cases
        do_op(16'h4400, 16'h4600, "4x6");
        do_op(16'h4000, 16'hC400, "2x-4");
        do_op(16'h3C01, 16'h3C01, "rne");
        do_op(16'h3E00, 16'h3E00, "norm");
        do_op(16'h7BFF, 16'h4000, "ovf");
        do_op(16'h7C00, 16'h0000, "inf*0");
        do_op(16'h7E00, 16'h3C00, "nan");
        do_op(16'h8000, 16'h4000, "negzero");
        do_op(16'h0001, 16'h3C00, "subn");
        do_op(16'h0400, 16'h0400, "unf");
        do_op(16'h8400, 16'h0400, "unf neg");
        do_op(16'hFC00, 16'h4000, "-inf");

        // Asynchronous reset in the middle of an operation (P is non-zero now)
        do_op(16'h4400, 16'h4600, "pre-rst");
        @(negedge clk);
        a = 16'h4000; b = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("midop rst P", P, 16'h0000);
        check_eq("midop rst ready", ready, 0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check_eq("post rst no ready", pulses, 0);
        check_eq("post rst P", P, 16'h0000);

        // Back-to-back with start held high
        @(negedge clk);
        a = 16'h4400; b = 16'h4600; start = 1'b1;
        cyc = 0; pulses = 0; last = 0; gap_bad = 0;
        while (pulses < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                pulses++;
                if (pulses == 1) check_eq("b2b first lat", cyc, 4);
                else if (cyc - last != 4) gap_bad++;
                last = cyc;
                if (pulses <= 2) check_eq("b2b P old", P, 16'h4E00);
                else             check_eq("b2b P new", P, 16'hC800);
                // New operands arrive while the second op is already in flight.
                if (pulses == 1) begin
                    @(negedge clk);
                    cyc++;
                    check_eq("b2b ready one cycle", ready, 0);
                    a = 16'h4000; b = 16'hC400;
                end
            end
        end
        check_eq("b2b pulses", pulses, 4);
        check_eq("b2b spacing", gap_bad, 0);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Randomized operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            do_op(ra, rb, $sformatf("rand%0d %h*%h", i, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
